inv_restorer_17: RTL and testbench

- Reverse of the 16-bit negation converter used by the radix-4 Booth partial-product generator.
- Takes a 17-bit two's-complement negated value y and recovers the 16-bit operand x = -y.
- Flags when -y is not representable in 16 bits.
- Computes nibble-serially (one 4-bit digit per clock) behind a valid/ready handshake. Used as a low-area checker/restorer beside the multiplier datapath.

---
 rtl/mult_pkg.sv | 18 +
 rtl/nibble_neg_slice.sv | 13 +
 rtl/inv_restorer_17.sv | 101 ++++++++++
 tb/tb_inv_restorer_17.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the Booth negation converter and its restorer.
package mult_pkg;

  localparam int DW     = 16;
  localparam int DIG    = 4;
  localparam int IN_W   = DW + 1;
  localparam int BEATS  = (IN_W + DIG - 1) / DIG;
  localparam int PAD_W  = BEATS * DIG;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int IDX_W  = $clog2(PAD_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_neg_slice.sv
// One digit of ~y + carry: inverts a DIG-bit digit and adds the incoming carry.
module nibble_neg_slice
  import mult_pkg::*;
(
  input  logic [DIG-1:0] d,
  input  logic           cin,
  output logic [DIG-1:0] s,
  output logic           cout
);

  assign {cout, s} = {1'b0, ~d} + {{DIG{1'b0}}, cin};

endmodule

// File: rtl/inv_restorer_17.sv
// Digit-serial restorer: recovers x = -y from a 17-bit negated value, one digit per clock,
// and flags results that do not fit in 16 signed bits.
module inv_restorer_17
  import mult_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [IN_W-1:0] y_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [DW-1:0]   x_o,
  output logic            ovf_o,
  output logic            busy_o
);

  state_e             state_r;
  logic [BEAT_W-1:0]  beat_r;
  logic               carry_r;
  logic [PAD_W-1:0]   y_r;
  logic [PAD_W-1:0]   r_r;
  logic [PAD_W-1:0]   r_next_s;
  logic [IDX_W-1:0]   idx_s;
  logic [DIG-1:0]     d_s;
  logic [DIG-1:0]     s_s;
  logic               c_s;

  nibble_neg_slice u_slice (
    .d    (d_s),
    .cin  (carry_r),
    .s    (s_s),
    .cout (c_s)
  );

  // Select the current digit and merge the slice result into the accumulated value.
  always_comb begin
    idx_s    = IDX_W'(beat_r * DIG);
    d_s      = DIG'(y_r >> idx_s);
    r_next_s = (r_r & ~(PAD_W'({DIG{1'b1}}) << idx_s)) | (PAD_W'(s_s) << idx_s);
  end

  // Handshake FSM and datapath registers; every output is driven from a flop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      beat_r      <= '0;
      carry_r     <= 1'b1;
      y_r         <= '0;
      r_r         <= '0;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      x_o         <= '0;
      ovf_o       <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid_i) begin
            y_r        <= PAD_W'(y_i);
            r_r        <= '0;
            carry_r    <= 1'b1;
            beat_r     <= '0;
            state_r    <= CALC;
            in_ready_o <= 1'b0;
            busy_o     <= 1'b1;
          end
        end
        CALC: begin
          r_r     <= r_next_s;
          carry_r <= c_s;
          beat_r  <= beat_r + BEAT_W'(1);
          // The final carry out of the top digit is discarded (modulo 2^17).
          if (beat_r == BEAT_W'(BEATS - 1)) begin
            state_r     <= DONE;
            out_valid_o <= 1'b1;
            x_o         <= r_next_s[DW-1:0];
            ovf_o       <= r_next_s[DW] ^ r_next_s[DW-1];
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_r     <= IDLE;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            busy_o      <= 1'b0;
            x_o         <= '0;
            ovf_o       <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_o <= 1'b0;
          in_ready_o  <= 1'b1;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_restorer_17.sv
// Directed bench for inv_restorer_17: boundary values, reset abort, backpressure, round trip.
module tb_inv_restorer_17;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] y_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] x_out;
  logic        ovf;
  logic        busy;

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  inv_restorer_17 dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .y_i         (y_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .x_o         (x_out),
    .ovf_o       (ovf),
    .busy_o      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    check_eq(tag, 32'(in_ready), 32'd1);
  endtask

  // Accept y, scramble inputs while busy, expect result after 5 cycles, consume it.
  task automatic run_one(input logic [16:0] y, input logic [15:0] ex, input logic ev, input string tag);
    int n;
    wait_ready({tag, "_rdy"});
    y_in     = y;
    in_valid = 1'b1;
    step();
    n = 0;
    while (!out_valid && n < 20) begin
      in_valid = 1'b1;
      y_in     = 17'($urandom);
      step();
      n++;
    end
    in_valid = 1'b0;
    check_eq({tag, "_lat"}, 32'(n), 32'd5);
    check_eq({tag, "_x"}, 32'(x_out), 32'(ex));
    check_eq({tag, "_ovf"}, 32'(ovf), 32'(ev));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq({tag, "_drop"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    int prev;
    logic        seen;
    logic [15:0] data;
    logic [16:0] ysx;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    y_in      = 17'h00000;
    #1;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_x", 32'(x_out), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    check_eq("rel_ready", 32'(in_ready), 32'd1);
    check_eq("rel_valid", 32'(out_valid), 32'd0);
    check_eq("rel_ovf", 32'(ovf), 32'd0);

    // Boundary vectors
    run_one(17'h08000, 16'h8000, 1'b0, "lower");
    run_one(17'h18000, 16'h8000, 1'b1, "neg32768");
    run_one(17'h10000, 16'h0000, 1'b1, "neg65536");
    run_one(17'h0FFFF, 16'h0001, 1'b1, "pos65535");
    run_one(17'h00000, 16'h0000, 1'b0, "zero");
    run_one(17'h1FFFF, 16'h0001, 1'b0, "minus1");
    run_one(17'h00005, 16'hFFFB, 1'b0, "plus5");

    // Reset in the middle of CALC
    wait_ready("mid_rdy");
    y_in     = 17'h12345;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    check_eq("mid_valid", 32'(out_valid), 32'd0);
    check_eq("mid_x", 32'(x_out), 32'd0);
    check_eq("mid_busy", 32'(busy), 32'd0);
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen = seen | out_valid | busy;
    end
    check_eq("mid_no_result", 32'(seen), 32'd0);
    run_one(17'h00005, 16'hFFFB, 1'b0, "after_rst");

    // Backpressure with a competing request in DONE
    wait_ready("bp_rdy");
    y_in     = 17'h1FFFF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check_eq("bp_lat", 32'(n), 32'd5);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      y_in     = 17'h00003;
      step();
      check_eq("bp_hold_x", 32'(x_out), 32'h0001);
      check_eq("bp_hold_v", 32'(out_valid), 32'd1);
      check_eq("bp_hold_rdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_eq("bp_rel_valid", 32'(out_valid), 32'd0);
    check_eq("bp_rel_ready", 32'(in_ready), 32'd1);
    check_eq("bp_rel_busy", 32'(busy), 32'd0);
    step();
    check_eq("bp_no_accept", 32'(busy), 32'd0);

    // Round trip through the forward converter with continuous handshake
    out_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 1500; i++) begin
      case (i)
        0:       data = 16'h8000;
        1:       data = 16'h7FFF;
        2:       data = 16'h0000;
        default: data = 16'($urandom);
      endcase
      ysx = {data[15], data};
      wait_ready("rt_rdy");
      y_in     = ~ysx + 17'd1;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
        step();
        n++;
      end
      check_eq("rt_x", 32'(x_out), 32'(data));
      check_eq("rt_ovf", 32'(ovf), 32'd0);
      if (i > 0) check_eq("rt_interval", 32'(cyc - prev), 32'd7);
      prev = cyc;
    end
    out_ready = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
